param_sp_ram: RTL and testbench

Parametrised single-port synchronous RAM, the successor to the fixed 64x8 single-port RAM. Adds generic width/depth, byte-lane write enables, a selectable read-during-write mode, an optional output register, and a sequential memory-clear engine in place of a one-cycle bulk reset. Used as a generic scratch/buffer store behind local controllers.

---
 rtl/param_sp_ram_pkg.sv | 15 +
 rtl/param_sp_ram_clear_ctrl.sv | 52 +++++
 rtl/param_sp_ram.sv | 121 ++++++++++++
 tb/tb_param_sp_ram.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_sp_ram_pkg.sv
// Shared definitions for the parametrised single-port RAM and its clear engine.
package param_sp_ram_pkg;

  // Read-during-write behaviour selectors
  localparam int RDW_NOCHANGE   = 0;
  localparam int RDW_READFIRST  = 1;
  localparam int RDW_WRITEFIRST = 2;

  // Clear engine states
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_t;

endpackage

// File: rtl/param_sp_ram_clear_ctrl.sv
// Sequential memory-clear engine: sweeps every address once after reset,
// issuing one zero-write per cycle, then parks in IDLE.
module ram_clear_ctrl
  import param_sp_ram_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state;
  logic [ADDR_W-1:0] ptr;

  // Clear FSM: reset restarts the sweep at address 0; leaves after the last word
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (ptr == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        IDLE: begin
          busy <= 1'b0;
        end
        default: begin
          state <= CLEAR;
          ptr   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/param_sp_ram.sv
// Parametrised single-port synchronous RAM with byte-lane writes, selectable
// read-during-write behaviour, optional output register and a clear engine.
module param_sp_ram
  import param_sp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 6,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              acc;
  logic              issue;
  logic [DATA_W-1:0] rd_word;

  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  // Overlay the enabled byte lanes of the new data onto the old word
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   lanes
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < BE_W; k++) begin
      if (lanes[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

  ram_clear_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // User requests only count once the clear sweep is done and reset is low
  assign acc   = en && !busy && !rst;
  assign issue = acc && (!we || (RDW_MODE != RDW_NOCHANGE));

  // Word presented to the read pipeline: stored word, or merged word in write-first mode
  always_comb begin
    rd_word = mem[addr];
    if (we && (RDW_MODE == RDW_WRITEFIRST)) begin
      rd_word = merge_bytes(mem[addr], din, be);
    end
  end

  // Array write port: clear sweep has priority, reset edge never touches contents
  always_ff @(posedge clk) begin
    if (clr_we && !rst) begin
      mem[clr_addr] <= '0;
    end else if (acc && we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= din[8*k +: 8];
      end
    end
  end

  // ---- stage p0: registered array read ----
  // Capture read data; hold it between accesses so dout stays stable
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= issue;
      if (issue) data_p0 <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              vld_p1;
      logic [DATA_W-1:0] data_p1;

      // ---- stage p1: optional output register ----
      // Extra pipeline stage; in-flight data is dropped on reset
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p1  <= 1'b0;
          data_p1 <= '0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) data_p1 <= data_p0;
        end
      end

      assign dout       = data_p1;
      assign dout_valid = vld_p1;
    end else begin : g_no_out_reg
      assign dout       = data_p0;
      assign dout_valid = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_param_sp_ram.sv
// Directed bench for param_sp_ram: three instances cover the default build,
// a 32-bit read-first build with output register, and a write-first build.
module tb_param_sp_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: defaults (8-bit, 64 words, no-change, OUT_REG=0)
  logic        en_a = 0, we_a = 0;
  logic [0:0]  be_a = 0;
  logic [5:0]  addr_a = 0;
  logic [7:0]  din_a = 0, dout_a;
  logic        dv_a, busy_a;

  // Instance B: 32-bit, 16 words, read-first, OUT_REG=1
  logic        en_b = 0, we_b = 0;
  logic [3:0]  be_b = 0;
  logic [3:0]  addr_b = 0;
  logic [31:0] din_b = 0, dout_b;
  logic        dv_b, busy_b;

  // Instance C: 8-bit, 16 words, write-first, OUT_REG=0
  logic        en_c = 0, we_c = 0;
  logic [0:0]  be_c = 0;
  logic [3:0]  addr_c = 0;
  logic [7:0]  din_c = 0, dout_c;
  logic        dv_c, busy_c;

  int total = 0;
  int bad   = 0;
  int cnt;
  logic dv_seen;

  always #5 clk = ~clk;

  param_sp_ram u_a (
    .clk(clk), .rst(rst), .en(en_a), .we(we_a), .be(be_a), .addr(addr_a),
    .din(din_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a)
  );

  param_sp_ram #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .OUT_REG(1)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .we(we_b), .be(be_b), .addr(addr_b),
    .din(din_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b)
  );

  param_sp_ram #(.DATA_W(8), .ADDR_W(4), .RDW_MODE(2), .OUT_REG(0)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .we(we_c), .be(be_c), .addr(addr_c),
    .din(din_c), .dout(dout_c), .dout_valid(dv_c), .busy(busy_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    step();
    check("rst_busy_a", {31'd0, busy_a}, 32'd1);
    check("rst_dv_a", {31'd0, dv_a}, 32'd0);
    check("rst_dout_a", {24'd0, dout_a}, 32'd0);
    check("rst_dv_b", {31'd0, dv_b}, 32'd0);
    check("rst_dout_b", dout_b, 32'd0);
    rst = 1'b0;

    // Clear duration: busy high for exactly 64 sampled cycles
    cnt = 0;
    while (busy_a && cnt < 200) begin
      cnt++;
      step();
    end
    check("clear_cycles", cnt, 32'd64);
    check("clear_dv_a", {31'd0, dv_a}, 32'd0);

    // Read all 64 addresses back-to-back: zero data, one valid per read
    for (int i = 0; i < 64; i++) begin
      en_a = 1; we_a = 0; addr_a = 6'(i);
      step();
      check("clr_rd_dv", {31'd0, dv_a}, 32'd1);
      check("clr_rd_dout", {24'd0, dout_a}, 32'd0);
    end
    en_a = 0;
    step();
    check("clr_rd_end_dv", {31'd0, dv_a}, 32'd0);

    // No-change mode (A): write gives no pulse, dout holds
    en_a = 1; we_a = 1; be_a = 1; addr_a = 3; din_a = 8'h55;
    step();
    check("nc_wr1_dv", {31'd0, dv_a}, 32'd0);
    we_a = 0;
    step();
    check("nc_rd1_dv", {31'd0, dv_a}, 32'd1);
    check("nc_rd1_dout", {24'd0, dout_a}, 32'h55);
    we_a = 1; din_a = 8'h66;
    step();
    check("nc_wr2_dv", {31'd0, dv_a}, 32'd0);
    check("nc_wr2_hold", {24'd0, dout_a}, 32'h55);
    we_a = 0;
    step();
    check("nc_rd2_dout", {24'd0, dout_a}, 32'h66);
    en_a = 0;
    step();
    check("nc_idle_dv", {31'd0, dv_a}, 32'd0);
    check("nc_idle_hold", {24'd0, dout_a}, 32'h66);

    // Write-first mode (C): dout shows merged post-write word
    en_c = 1; we_c = 1; be_c = 1; addr_c = 3; din_c = 8'h55;
    step();
    check("wf_wr1_dv", {31'd0, dv_c}, 32'd1);
    check("wf_wr1_dout", {24'd0, dout_c}, 32'h55);
    din_c = 8'h66;
    step();
    check("wf_wr2_dout", {24'd0, dout_c}, 32'h66);
    be_c = 0; din_c = 8'h77;
    step();
    check("wf_be0_dv", {31'd0, dv_c}, 32'd1);
    check("wf_be0_dout", {24'd0, dout_c}, 32'h66);
    en_c = 0;
    step();
    check("wf_idle_dv", {31'd0, dv_c}, 32'd0);
    check("wf_idle_hold", {24'd0, dout_c}, 32'h66);

    // Byte lanes + read-first with OUT_REG=1 (B)
    en_b = 1; we_b = 1; be_b = 4'hF; addr_b = 5; din_b = 32'hAABBCCDD;
    step();
    check("bl_w1_dv", {31'd0, dv_b}, 32'd0);
    be_b = 4'b0101; din_b = 32'h11223344;
    step();
    check("rf_w1_dv", {31'd0, dv_b}, 32'd1);
    check("rf_w1_old", dout_b, 32'h0);
    we_b = 0; be_b = 4'h0;
    step();
    check("rf_w2_dv", {31'd0, dv_b}, 32'd1);
    check("rf_w2_old", dout_b, 32'hAABBCCDD);
    en_b = 0;
    step();
    check("bl_rd_dv", {31'd0, dv_b}, 32'd1);
    check("bl_rd_dout", dout_b, 32'hAA22CC44);
    step();
    check("bl_end_dv", {31'd0, dv_b}, 32'd0);
    check("bl_end_hold", dout_b, 32'hAA22CC44);

    // Streaming reads with 2-cycle latency (B)
    for (int i = 0; i < 4; i++) begin
      en_b = 1; we_b = 1; be_b = 4'hF; addr_b = 4'(i); din_b = 32'h10 + i;
      step();
    end
    en_b = 0; we_b = 0;
    step();
    step();
    step();
    en_b = 1; we_b = 0; addr_b = 0;
    step();
    check("st_lat_dv", {31'd0, dv_b}, 32'd0);
    for (int i = 1; i < 5; i++) begin
      if (i < 4) addr_b = 4'(i);
      else en_b = 0;
      step();
      check("st_dv", {31'd0, dv_b}, 32'd1);
      check("st_dout", dout_b, 32'h10 + (i - 1));
    end
    step();
    check("st_end_dv", {31'd0, dv_b}, 32'd0);
    check("st_end_hold", dout_b, 32'h13);

    // Busy gating and mid-clear reset (A)
    en_a = 1; we_a = 1; be_a = 1; addr_a = 10; din_a = 8'h5A;
    step();
    we_a = 0;
    step();
    check("bg_pre_dout", {24'd0, dout_a}, 32'h5A);
    en_a = 0;
    rst = 1;
    step();
    rst = 0;
    en_a = 1; we_a = 1; be_a = 1; addr_a = 10; din_a = 8'hFF;
    for (int i = 0; i < 30; i++) step();
    check("bg_busy30", {31'd0, busy_a}, 32'd1);
    rst = 1;
    step();
    rst = 0;
    cnt = 0;
    dv_seen = 1'b0;
    while (busy_a && cnt < 200) begin
      if (dv_a) dv_seen = 1'b1;
      cnt++;
      step();
    end
    en_a = 0; we_a = 0;
    check("bg_clear_cycles", cnt, 32'd64);
    check("bg_no_dv", {31'd0, dv_seen}, 32'd0);
    en_a = 1; addr_a = 10;
    step();
    check("bg_rd_dv", {31'd0, dv_a}, 32'd1);
    check("bg_rd_dout", {24'd0, dout_a}, 32'h00);
    en_a = 0;
    step();

    // Reset mid-read (B): in-flight read dropped
    while (busy_b && cnt < 400) begin
      cnt++;
      step();
    end
    check("mr_idle", {31'd0, busy_b}, 32'd0);
    en_b = 1; we_b = 0; addr_b = 2;
    step();
    en_b = 0;
    rst = 1;
    step();
    check("mr_dv", {31'd0, dv_b}, 32'd0);
    check("mr_dout", dout_b, 32'd0);
    rst = 0;
    step();
    check("mr_dv2", {31'd0, dv_b}, 32'd0);
    check("mr_dout2", dout_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
